// File: rtl/gesture_i2c_seq_if.sv
// Transaction-level handshake between the gesture sequencer and the byte-level I2C master.
// The sequencer uses the master modport; the I2C master (or its model) uses the slave modport.
interface gesture_i2c_seq_if;
    logic       i2c_req;
    logic       i2c_rw;
    logic [7:0] i2c_reg;
    logic [7:0] i2c_wdata;
    logic       i2c_done;
    logic       i2c_nack;
    logic [7:0] i2c_rdata;

    modport master (
        output i2c_req,
        output i2c_rw,
        output i2c_reg,
        output i2c_wdata,
        input  i2c_done,
        input  i2c_nack,
        input  i2c_rdata
    );

    modport slave (
        input  i2c_req,
        input  i2c_rw,
        input  i2c_reg,
        input  i2c_wdata,
        output i2c_done,
        output i2c_nack,
        output i2c_rdata
    );
endinterface

// File: rtl/gesture_i2c_seq.sv
// Gesture sensor sequencer: power-up wait, wake access, table-driven configuration, then gesture polling.
// Optional macro GEST_IRQ_EN replaces timer polling with the sensor's int_n falling edge.
module gesture_i2c_seq #(
    parameter int unsigned WAIT_CYC  = 50000,
    parameter int unsigned CFG_NUM   = 51,
    parameter int unsigned POLL_CYC  = 2500000,
    parameter logic [7:0]  GEST_REG  = 8'h43,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic                     sys_clk,
    input  logic                     sys_rstn,
`ifdef GEST_IRQ_EN
    input  logic                     int_n,
`endif
    output logic [7:0]               cfg_idx,
    input  logic [15:0]              cfg_data,
    gesture_i2c_seq_if.master        i2c,
    output logic                     cfg_done,
    output logic                     gest_valid,
    output logic [7:0]               gest_code,
    output logic                     err
);

    typedef enum logic [3:0] {
        PWR_WAIT,
        WAKE_REQ,
        WAKE_WAIT,
        WAKE_DLY,
        CFG_FETCH,
        CFG_REQ,
        CFG_WAIT,
        POLL_WAIT,
        READ_REQ,
        READ_WAIT,
        READ_RETRY,
        ERROR
    } state_t;

    localparam logic [31:0] WAIT_LAST = 32'(WAIT_CYC - 1);
    localparam logic [7:0]  CFG_LAST  = 8'(CFG_NUM - 1);
    localparam logic [7:0]  RETRY_LIM = 8'(RETRY_MAX);
`ifndef GEST_IRQ_EN
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYC - 1);
`endif

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  cfg_idx_q, cfg_idx_d;
    logic        req_q, req_d;
    logic        rw_q, rw_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        cfg_done_q, cfg_done_d;
    logic        gest_valid_q, gest_valid_d;
    logic [7:0]  gest_code_q, gest_code_d;
    logic        err_q, err_d;
`ifdef GEST_IRQ_EN
    logic [2:0]  int_sync_q, int_sync_d;
    logic        pend_q, pend_d;
    logic        irq_fall;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        retry_d      = retry_q;
        cfg_idx_d    = cfg_idx_q;
        req_d        = req_q;
        rw_d         = rw_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        cfg_done_d   = cfg_done_q;
        gest_valid_d = 1'b0;
        gest_code_d  = gest_code_q;
        err_d        = err_q;
`ifdef GEST_IRQ_EN
        // Stages [1:0] synchronize int_n; stage [2] is the previous sample for edge detection.
        int_sync_d = {int_sync_q[1:0], int_n};
        irq_fall   = int_sync_q[2] & ~int_sync_q[1];
        pend_d     = pend_q | irq_fall;
`endif

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = WAKE_REQ;
                    req_d   = 1'b1;
                    rw_d    = 1'b0;
                    reg_d   = 8'h00;
                    wdata_d = 8'h00;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // The sensor is asleep during the wake access, so its NACK is expected and ignored.
            WAKE_REQ, WAKE_WAIT: begin
                if (i2c.i2c_done) begin
                    state_d = WAKE_DLY;
                    req_d   = 1'b0;
                end else begin
                    state_d = WAKE_WAIT;
                end
            end
            WAKE_DLY: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d   = CFG_FETCH;
                    cfg_idx_d = 8'h00;
                    retry_d   = 8'h00;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            CFG_FETCH: begin
                state_d = CFG_REQ;
                req_d   = 1'b1;
                rw_d    = 1'b0;
                reg_d   = cfg_data[15:8];
                wdata_d = cfg_data[7:0];
            end
            // A NACK retry goes back through CFG_FETCH so i2c_req drops for a cycle between attempts.
            CFG_REQ, CFG_WAIT: begin
                if (i2c.i2c_done) begin
                    req_d = 1'b0;
                    if (!i2c.i2c_nack) begin
                        retry_d = 8'h00;
                        if (cfg_idx_q == CFG_LAST) begin
                            cfg_done_d = 1'b1;
                            state_d    = POLL_WAIT;
                        end else begin
                            cfg_idx_d = cfg_idx_q + 8'd1;
                            state_d   = CFG_FETCH;
                        end
                    end else if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 8'd1;
                        state_d = CFG_FETCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end
                end else begin
                    state_d = CFG_WAIT;
                end
            end
            POLL_WAIT: begin
`ifdef GEST_IRQ_EN
                if (irq_fall || pend_q) begin
                    pend_d  = 1'b0;
`else
                if (cnt_q == POLL_LAST) begin
`endif
                    state_d = READ_REQ;
                    req_d   = 1'b1;
                    rw_d    = 1'b1;
                    reg_d   = GEST_REG;
                    wdata_d = 8'h00;
                    retry_d = 8'h00;
                end else begin
`ifndef GEST_IRQ_EN
                    cnt_d = cnt_q + 32'd1;
`endif
                end
            end
            // A zero result means no gesture, so the last reported code is kept.
            READ_REQ, READ_WAIT: begin
                if (i2c.i2c_done) begin
                    req_d = 1'b0;
                    if (!i2c.i2c_nack) begin
                        retry_d = 8'h00;
                        state_d = POLL_WAIT;
                        if (i2c.i2c_rdata != 8'h00) begin
                            gest_code_d  = i2c.i2c_rdata;
                            gest_valid_d = 1'b1;
                        end
                    end else if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 8'd1;
                        state_d = READ_RETRY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end
                end else begin
                    state_d = READ_WAIT;
                end
            end
            READ_RETRY: begin
                state_d = READ_REQ;
                req_d   = 1'b1;
            end
            ERROR: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = PWR_WAIT;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= '0;
            retry_q      <= '0;
            cfg_idx_q    <= '0;
            req_q        <= 1'b0;
            rw_q         <= 1'b0;
            reg_q        <= '0;
            wdata_q      <= '0;
            cfg_done_q   <= 1'b0;
            gest_valid_q <= 1'b0;
            gest_code_q  <= '0;
            err_q        <= 1'b0;
`ifdef GEST_IRQ_EN
            int_sync_q   <= 3'b111;
            pend_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            cfg_idx_q    <= cfg_idx_d;
            req_q        <= req_d;
            rw_q         <= rw_d;
            reg_q        <= reg_d;
            wdata_q      <= wdata_d;
            cfg_done_q   <= cfg_done_d;
            gest_valid_q <= gest_valid_d;
            gest_code_q  <= gest_code_d;
            err_q        <= err_d;
`ifdef GEST_IRQ_EN
            int_sync_q   <= int_sync_d;
            pend_q       <= pend_d;
`endif
        end
    end

    assign i2c.i2c_req   = req_q;
    assign i2c.i2c_rw    = rw_q;
    assign i2c.i2c_reg   = reg_q;
    assign i2c.i2c_wdata = wdata_q;
    assign cfg_idx       = cfg_idx_q;
    assign cfg_done      = cfg_done_q;
    assign gest_valid    = gest_valid_q;
    assign gest_code     = gest_code_q;
    assign err           = err_q;

endmodule

// File: tb/tb_gesture_i2c_seq.sv
// Directed bench for gesture_i2c_seq with shortened waits; an I2C master model answers every request after LAT cycles.
// Follows GEST_IRQ_EN the same way the design does.
module tb_gesture_i2c_seq;

    localparam int unsigned WAIT_CYC  = 20;
    localparam int unsigned CFG_NUM   = 24;
    localparam int unsigned POLL_CYC  = 60;
    localparam int unsigned RETRY_MAX = 3;
    localparam int unsigned LAT       = 10;
    localparam logic [7:0]  GEST_REG  = 8'h43;

    logic        sys_clk = 1'b0;
    logic        sys_rstn;
    logic [7:0]  cfg_idx;
    logic [15:0] cfg_data;
    logic        cfg_done, gest_valid, err;
    logic [7:0]  gest_code;
`ifdef GEST_IRQ_EN
    logic        int_n;
`endif

    gesture_i2c_seq_if bus();

    gesture_i2c_seq #(
        .WAIT_CYC (WAIT_CYC),
        .CFG_NUM  (CFG_NUM),
        .POLL_CYC (POLL_CYC),
        .GEST_REG (GEST_REG),
        .RETRY_MAX(RETRY_MAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rstn  (sys_rstn),
`ifdef GEST_IRQ_EN
        .int_n     (int_n),
`endif
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .i2c       (bus),
        .cfg_done  (cfg_done),
        .gest_valid(gest_valid),
        .gest_code (gest_code),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] tbl(input logic [7:0] idx);
        return {idx + 8'h10, (idx * 8'd7) ^ 8'h5A};
    endfunction

    assign cfg_data = tbl(cfg_idx);

    // Master model controls, written only by the stimulus.
    logic [7:0] nack_entry = 8'd0;
    int         nack_budget = 0;
    logic [7:0] rd_value = 8'h00;
    logic       spur_done = 1'b0;

    logic       r_busy, r_cool, resp_done, resp_nack;
    logic [7:0] resp_rdata;
    int         r_lat, cfg_nacks;

    assign bus.i2c_done  = resp_done | spur_done;
    assign bus.i2c_nack  = resp_nack;
    assign bus.i2c_rdata = resp_rdata;

    // Done arrives LAT cycles after req is seen; a cool-down cycle keeps a still-high req from restarting it.
    always @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_busy <= 1'b0; r_cool <= 1'b0; r_lat <= 0;
            resp_done <= 1'b0; resp_nack <= 1'b0; resp_rdata <= 8'h00; cfg_nacks <= 0;
        end else begin
            resp_done <= 1'b0;
            resp_nack <= 1'b0;
            if (r_cool) begin
                r_cool <= 1'b0;
            end else if (!r_busy) begin
                if (bus.i2c_req) begin r_busy <= 1'b1; r_lat <= 1; end
            end else if (r_lat == int'(LAT) - 1) begin
                r_busy     <= 1'b0;
                r_cool     <= 1'b1;
                resp_done  <= 1'b1;
                resp_rdata <= bus.i2c_rw ? rd_value : 8'h00;
                if (!bus.i2c_rw && bus.i2c_reg != 8'h00 && cfg_idx == nack_entry && cfg_nacks < nack_budget) begin
                    resp_nack <= 1'b1;
                    cfg_nacks <= cfg_nacks + 1;
                end
            end else begin
                r_lat <= r_lat + 1;
            end
        end
    end

    int checks = 0, failures = 0;
    int tb_cyc, log_n, gv_n, gv_cyc, cfd_cyc, err_cyc, proto_err = 0;
    logic req_prev, done_prev;
    logic [7:0] gv_code;
    logic       log_rw   [128];
    logic [7:0] log_reg  [128];
    logic [7:0] log_wdata[128];
    logic [7:0] log_idx  [128];
    int         log_cyc  [128];
    int         log_done [128];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {12'b0, bus.i2c_req, cfg_idx, cfg_done, gest_valid, gest_code, err};
    endfunction

    // One clock: sample #1 after the edge, log request starts and check the handshake rules.
    task automatic applyStimulus();
        @(posedge sys_clk);
        #1;
        tb_cyc++;
        if (done_prev && bus.i2c_req) proto_err++;
        if (bus.i2c_req && !req_prev && log_n < 128) begin
            log_rw[log_n] = bus.i2c_rw;   log_reg[log_n] = bus.i2c_reg;
            log_wdata[log_n] = bus.i2c_wdata; log_idx[log_n] = cfg_idx;
            log_cyc[log_n] = tb_cyc;      log_done[log_n] = 0;
            log_n++;
        end else if (bus.i2c_req && log_n > 0) begin
            if (bus.i2c_rw !== log_rw[log_n-1] || bus.i2c_reg !== log_reg[log_n-1] ||
                bus.i2c_wdata !== log_wdata[log_n-1]) proto_err++;
        end
        if (bus.i2c_done && bus.i2c_req && log_n > 0) log_done[log_n-1] = tb_cyc;
        if (gest_valid) begin gv_n++; gv_cyc = tb_cyc; gv_code = gest_code; end
        if (cfg_done && cfd_cyc == 0) cfd_cyc = tb_cyc;
        if (err && err_cyc == 0) err_cyc = tb_cyc;
        req_prev  = bus.i2c_req;
        done_prev = bus.i2c_done && bus.i2c_req;
    endtask

    task automatic holdReset(input string tag);
        sys_rstn = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        checkOutput(tag, outs(), 32'h0);
        @(negedge sys_clk);
        sys_rstn = 1'b1;
        tb_cyc = 0; log_n = 0; gv_n = 0; gv_cyc = 0; cfd_cyc = 0; err_cyc = 0;
        req_prev = 1'b0; done_prev = 1'b0;
    endtask

    initial begin
        int bad, n5, last5, rd1, gap, t0;
        sys_rstn = 1'b0;
`ifdef GEST_IRQ_EN
        int_n = 1'b1;
`endif
        $display("[TB] start");

        // Clean configuration pass, with a stray done pulse while no request is open.
        holdReset("reset_outputs_a");
        for (int i = 0; i < int'(WAIT_CYC) + 5 && log_n == 0; i++) begin
            if (i == 5) spur_done = 1'b1;
            applyStimulus();
            spur_done = 1'b0;
        end
        checkOutput("first_req_cycle", 32'((log_n > 0) ? log_cyc[0] : 0), 32'(WAIT_CYC));
        checkOutput("wake_access", {15'b0, log_rw[0], log_reg[0], log_wdata[0]}, 32'h0);
        for (int i = 0; i < 1500 && !cfg_done; i++) applyStimulus();
        checkOutput("cfg_done_a", 32'(cfg_done), 32'd1);
        checkOutput("write_count_a", 32'(log_n), 32'(CFG_NUM + 1));
        gap = log_cyc[1] - log_done[0];
        checkOutput("post_wake_gap", 32'(gap >= int'(WAIT_CYC) && gap <= int'(WAIT_CYC) + 3), 32'd1);
        bad = 0;
        for (int i = 0; i < int'(CFG_NUM); i++)
            if ({log_rw[i+1], log_reg[i+1], log_wdata[i+1]} !== {1'b0, tbl(8'(i))}) bad++;
        checkOutput("table_order", 32'(bad), 32'd0);
        checkOutput("cfg_done_timing", 32'(cfd_cyc), 32'(log_done[CFG_NUM] + 1));
        checkOutput("err_a", 32'(err), 32'd0);

        // Entry 5 NACKed twice, then accepted.
        nack_entry = 8'd5; nack_budget = 2;
        holdReset("reset_outputs_b");
        for (int i = 0; i < 1500 && !cfg_done; i++) applyStimulus();
        checkOutput("cfg_done_b", 32'(cfg_done), 32'd1);
        checkOutput("write_count_b", 32'(log_n), 32'(CFG_NUM + 3));
        n5 = 0; bad = 0; last5 = 0;
        for (int i = 1; i < log_n; i++)
            if (log_idx[i] == 8'd5) begin
                n5++; last5 = i;
                if ({log_reg[i], log_wdata[i]} !== tbl(8'd5)) bad++;
            end
        checkOutput("entry5_attempts", 32'(n5), 32'd3);
        checkOutput("entry5_identical", 32'(bad), 32'd0);
        checkOutput("advance_to_6", 32'(log_idx[last5 + 1]), 32'd6);
        checkOutput("err_b", 32'(err), 32'd0);

        // Gesture reads: 01 is reported, 00 is not.
        rd_value = 8'h01;
        rd1 = log_n;
`ifdef GEST_IRQ_EN
        applyStimulus();
        int_n = 1'b0;
        t0 = tb_cyc;
        for (int i = 0; i < 10 && log_n <= rd1; i++) applyStimulus();
        checkOutput("irq_read_latency", 32'(log_n > rd1 && log_cyc[rd1] - t0 <= 4), 32'd1);
        repeat (2) applyStimulus();
        int_n = 1'b1;
        repeat (3) applyStimulus();
        int_n = 1'b0;
`endif
        for (int i = 0; i < 300 && gv_n == 0; i++) applyStimulus();
        rd_value = 8'h00;
        checkOutput("gest_pulse_seen", 32'(gv_n), 32'd1);
        checkOutput("gest_code_01", 32'(gv_code), 32'h01);
        checkOutput("read_access", {23'b0, log_rw[rd1], log_reg[rd1]}, {23'b0, 1'b1, GEST_REG});
        checkOutput("gest_pulse_timing", 32'(gv_cyc), 32'(log_done[rd1] + 1));
        applyStimulus();
        checkOutput("gest_pulse_width", 32'(gest_valid), 32'd0);
`ifndef GEST_IRQ_EN
        checkOutput("first_read_time", 32'(log_cyc[rd1]), 32'(cfd_cyc + int'(POLL_CYC)));
`endif
        for (int i = 0; i < 200 && log_n <= rd1 + 1; i++) applyStimulus();
`ifdef GEST_IRQ_EN
        int_n = 1'b1;
        checkOutput("pending_read_time", 32'(log_cyc[rd1 + 1]), 32'(log_done[rd1] + 2));
`else
        checkOutput("read_spacing", 32'(log_cyc[rd1 + 1] - log_cyc[rd1]), 32'(POLL_CYC + LAT + 1));
`endif
        repeat (LAT + 5) applyStimulus();
        checkOutput("zero_read_no_pulse", 32'(gv_n), 32'd1);
        checkOutput("gest_code_held", 32'(gest_code), 32'h01);

        // Entry 5 NACKed four times: retries exhausted.
        nack_entry = 8'd5; nack_budget = 4;
        holdReset("reset_outputs_c");
        for (int i = 0; i < 1500 && !err; i++) applyStimulus();
        checkOutput("err_set", 32'(err), 32'd1);
        checkOutput("err_timing", 32'(err_cyc), 32'(log_done[log_n - 1] + 1));
        n5 = 0;
        for (int i = 1; i < log_n; i++) if (log_idx[i] == 8'd5) n5++;
        checkOutput("entry5_attempts_err", 32'(n5), 32'd4);
        t0 = log_n;
        repeat (100) applyStimulus();
        checkOutput("no_req_after_err", 32'(log_n - t0), 32'd0);
        checkOutput("err_state_outputs", {29'b0, bus.i2c_req, cfg_done, err}, 32'd1);

        // Asynchronous reset in the middle of entry 20.
        nack_budget = 0;
        holdReset("reset_outputs_e");
        for (int i = 0; i < 1500 && !(log_n > 0 && log_idx[log_n - 1] == 8'd20); i++) applyStimulus();
        repeat (3) applyStimulus();
        checkOutput("pre_reset_state", {23'b0, bus.i2c_req, cfg_idx}, {23'b0, 1'b1, 8'd20});
        #2;
        sys_rstn = 1'b0;
        #1;
        checkOutput("async_reset_outputs", outs(), 32'h0);
        holdReset("reset_outputs_e2");
        for (int i = 0; i < 200 && log_n < 2; i++) applyStimulus();
        checkOutput("restart_wait", 32'(log_cyc[0]), 32'(WAIT_CYC));
        checkOutput("restart_entry0", {8'b0, log_idx[1], log_reg[1], log_wdata[1]}, {8'b0, 8'd0, tbl(8'd0)});

        checkOutput("protocol_violations", 32'(proto_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
